// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter around a 4:1 one-bit mux: picks an owner, drives the select, gates out with valid.
// Define MUX_ARB_TIMEOUT_EN to force-release a grant after MAX_BEATS consecutive cycles.
module mux_rr_arbiter #(
  parameter int MAX_BEATS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] x,
  output logic [1:0] a,
  output logic [3:0] gnt,
  output logic       valid,
  output logic       out
);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]       r_state;
  logic [3:0]       r_gnt;
  logic [1:0]       r_a;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_ptr;

  logic [3:0] w_excl;
  logic [3:0] w_cand;
  logic [1:0] w_pick;
  logic       w_pick_vld;
  logic       w_tmo;
  logic       w_release;

  // Excluding the current owner only matters on a timeout (on a req drop its bit is already 0);
  // if it is the sole requester it falls back in and is re-granted.
  assign w_excl = req & ~r_gnt;
  assign w_cand = (|w_excl) ? w_excl : req;

  always_comb begin
    w_pick     = r_ptr;
    w_pick_vld = 1'b0;
    for (int j = 3; j >= 0; j--) begin
      if (w_cand[r_ptr + 2'(j)]) begin
        w_pick     = r_ptr + 2'(j);
        w_pick_vld = 1'b1;
      end
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  assign w_tmo = (r_cnt == CNT_LAST);
`else
  assign w_tmo = 1'b0;
`endif

  assign w_release = ~req[r_a] | w_tmo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_a     <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_state <= S_GRANT;
            r_gnt   <= 4'b0001 << w_pick;
            r_a     <= w_pick;
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_ptr   <= w_pick + 2'd1;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            if (w_pick_vld) begin
              r_gnt   <= 4'b0001 << w_pick;
              r_a     <= w_pick;
              r_cnt   <= '0;
              r_ptr   <= w_pick + 2'd1;
            end else begin
              r_state <= S_IDLE;
              r_gnt   <= '0;
              r_valid <= 1'b0;
            end
          end else if (r_cnt != CNT_LAST) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign a     = r_a;
  assign gnt   = r_gnt;
  assign valid = r_valid;
  assign out   = r_valid & x[r_a];
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed vector table, corner sequences, and randomized run vs a reference model.
module tb_mux_rr_arbiter;
  localparam int MAXB = 4;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] x;
  logic [1:0] a;
  logic [3:0] gnt;
  logic       valid;
  logic       out;

  int tests = 0;
  int fails = 0;

  mux_rr_arbiter #(.MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst(rst), .req(req), .x(x),
    .a(a), .gnt(gnt), .valid(valid), .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] x;
    logic [3:0] gnt;
    logic [1:0] a;
    logic       valid;
    logic       out;
  } vec_t;

  vec_t tbl[13];

  // reference model state: owner index (-1 idle), rr pointer, cycles held, last select
  int m_owner, m_ptr, m_beats, m_a;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] eg, input logic [1:0] ea,
                         input logic ev, input logic eo);
    chk({nm, ".gnt"},   gnt,          eg);
    chk({nm, ".a"},     {2'b00, a},   {2'b00, ea});
    chk({nm, ".valid"}, {3'b0, valid}, {3'b0, ev});
    chk({nm, ".out"},   {3'b0, out},  {3'b0, eo});
  endtask

  task automatic cyc(input logic r, input logic [3:0] rq, input logic [3:0] xx);
    rst = r; req = rq; x = xx;
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [3:0] c, input int p);
    for (int j = 0; j < 4; j++) begin
      if (c[(p + j) % 4]) return (p + j) % 4;
    end
    return -1;
  endfunction

  function automatic int popc(input logic [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  task automatic m_grant(input int k);
    m_owner = k; m_a = k; m_ptr = (k + 1) % 4; m_beats = 0;
  endtask

  task automatic model_step(input logic r, input logic [3:0] rq);
    int k;
    logic [3:0] cand;
    bit drop, tmo;
    if (r) begin
      m_owner = -1; m_ptr = 0; m_beats = 0; m_a = 0;
    end else if (m_owner < 0) begin
      k = pick(rq, m_ptr);
      if (k >= 0) m_grant(k);
    end else begin
      drop = !rq[m_owner];
      tmo  = TMO && (m_beats == MAXB - 1);
      if (drop || tmo) begin
        cand = rq;
        if (!drop && popc(rq) > 1) cand[m_owner] = 1'b0;
        k = pick(cand, m_ptr);
        if (k >= 0) m_grant(k);
        else m_owner = -1;
      end else begin
        m_beats++;
      end
    end
  endtask

  initial begin
    logic [3:0] rq, xx;
    logic r;
    int idx;
    rst = 1'b1; req = 4'h0; x = 4'h0;

    // reset, release, owner 3 -> owner 0 without bubble, idle, mid-grant reset
    tbl[0]  = '{1'b1, 4'hF, 4'h5, 4'h0, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'hF, 4'h5, 4'h0, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'hF, 4'h5, 4'h1, 2'd0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 4'h8, 4'h5, 4'h8, 2'd3, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 4'h9, 4'h5, 4'h8, 2'd3, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 4'h1, 4'h5, 4'h1, 2'd0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 4'h0, 4'h5, 4'h0, 2'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'h4, 4'h5, 4'h4, 2'd2, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 4'hC, 4'h5, 4'h0, 2'd0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'hC, 4'h5, 4'h4, 2'd2, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 4'hC, 4'hA, 4'h4, 2'd2, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 4'h0, 4'h5, 4'h0, 2'd2, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 4'h0, 4'hA, 4'h0, 2'd2, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].rst, tbl[i].req, tbl[i].x);
      chk_all($sformatf("tbl%0d", i), tbl[i].gnt, tbl[i].a, tbl[i].valid, tbl[i].out);
    end

    // single requester held: grant stays on 1 (re-granted on timeout if enabled)
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 4'h2, 4'h5);
      chk_all($sformatf("hold%0d", i), 4'h2, 2'd1, 1'b1, 1'b0);
    end
    cyc(1'b0, 4'h0, 4'h5);
    chk_all("hold_drop", 4'h0, 2'd1, 1'b0, 1'b0);

    cyc(1'b1, 4'h0, 4'h5);
    chk_all("rst2", 4'h0, 2'd0, 1'b0, 1'b0);
`ifdef MUX_ARB_TIMEOUT_EN
    // full contention rotates every MAX_BEATS cycles with no idle slot
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 4'hF, 4'h5);
      idx = (i / MAXB) % 4;
      chk_all($sformatf("tmo%0d", i), 4'(1 << idx), 2'(idx), 1'b1, ~idx[0]);
    end
`else
    // no timeout: owner 0 keeps the grant indefinitely
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 4'hF, 4'h5);
      chk_all($sformatf("keep%0d", i), 4'h1, 2'd0, 1'b1, 1'b1);
    end
    cyc(1'b0, 4'hE, 4'h5);
    chk_all("keep_rel", 4'h2, 2'd1, 1'b1, 1'b0);
    cyc(1'b0, 4'hD, 4'h5);
    chk_all("ptr2", 4'h4, 2'd2, 1'b1, 1'b1);
`endif

    // randomized run against the reference model
    cyc(1'b1, 4'h0, 4'h0);
    model_step(1'b1, 4'h0);
    rq = 4'h0;
    for (int i = 0; i < 500; i++) begin
      r  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      xx = 4'($urandom_range(0, 15));
      cyc(r, rq, xx);
      model_step(r, rq);
      chk_all($sformatf("rnd%0d", i),
              (m_owner >= 0) ? 4'(1 << m_owner) : 4'h0,
              2'(m_a),
              m_owner >= 0,
              (m_owner >= 0) ? xx[m_a] : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the 4:1 one-bit mux datapath (data x[3:0], select a[1:0], output out).
- Four requesters share the single output bit. The block decides which requester owns the mux, drives the select, and gates the muxed output with a valid flag.
- Contains the mux itself, so it is a drop-in controlled replacement for a bare mux instance.

Parameters:
MAX_BEATS, 4, maximum consecutive cycles one requester may hold the grant when the timeout feature is compiled in; legal range >= 1.
CNT_W, $clog2(MAX_BEATS+1), width of the internal beat counter; derived, not overridden.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
req  input  4  request per requester; req[i] asserted means requester i wants the output
x  input  4  data bits; x[i] belongs to requester i
a  output  2  registered mux select = index of the current grantee
gnt  output  4  registered one-hot grant; 0000 when idle
valid  output  1  registered; 1 while a grant is active
out  output  1  combinational: valid ? x[a] : 0

Behaviour:
- Reset (rst=1 sampled at an edge):
  - Next cycle: state=IDLE, gnt=0000, a=00, valid=0, out=0, beat counter=0, RR pointer ptr=0.
  - Applies mid-grant too: the grant is dropped at that edge and no partial state survives.
- States: IDLE, GRANT.
- RR pick:
  - Search order is ptr, ptr+1, ... mod 4; the first asserted candidate wins.
  - On every new grant to index k, ptr <= (k+1) mod 4.
- IDLE:
  - req == 0000: stay IDLE.
  - Otherwise pick k, go to GRANT. At the next edge gnt=onehot(k), a=k, valid=1, counter=0.
  - Latency req -> gnt is exactly 1 cycle.
- GRANT, each edge:
  - Release condition is req[a]==0, or (timeout enabled and counter==MAX_BEATS-1).
  - No release: counter increments, grant unchanged.
  - Release with another requester asserted: re-pick from the current ptr and stay in GRANT. New gnt/a appear at the next edge with counter=0. No idle bubble.
    - On a timeout release, the current grantee is excluded from candidates unless it is the only requester, in which case it is re-granted and the counter is reset.
  - Release with no requester asserted: go to IDLE. Next cycle gnt=0000, valid=0, a holds its last value, out=0.
- req[a] dropping and timeout in the same cycle: treated as a single release (req-drop semantics).
- Requests arriving in GRANT wait; they are not pre-empted.
- gnt is always one-hot or zero, and a == index of the gnt bit whenever valid=1.
- out is purely combinational from x and the registered a/valid. No added latency on x.

Optional Feature:
MUX_ARB_TIMEOUT_EN
- Defined: grant is force-released after MAX_BEATS consecutive cycles (counter==MAX_BEATS-1), as above. Guarantees fairness under continuous requests.
- Undefined: the timeout term is removed and release happens only when req[a] drops. The beat counter still counts but saturates at MAX_BEATS-1 and has no effect on outputs.

Test Plan:
1. rst=1 for 2 cycles with req=1111, x=0101 -> after reset gnt=0000, a=00, valid=0, out=0. Release rst -> next cycle gnt=0001, a=00, out=1.
2. req=0010 held 6 cycles, x=0101, timeout undefined -> one cycle later gnt=0010, a=01, valid=1, out=0, held all 6 cycles. Drop req -> next cycle valid=0, out=0.
3. MUX_ARB_TIMEOUT_EN, MAX_BEATS=4, req=1111 constant, x=0101 -> grants 0,1,2,3,0 each for exactly 4 cycles; out sequence 1,0,1,0,1 per 4-cycle slot; no idle cycles.
4. Timeout undefined, req=1111 -> gnt=0001 for 20 cycles. Then req=1110 -> next cycle gnt=0010, a=01; ptr now 2.
5. Grant on requester 3 (req=1000), then req=1001 and drop bit 3 (req=0001) -> next cycle gnt=0001 with no IDLE bubble. Then req=0000 -> IDLE next cycle.
6. Mid-grant reset: gnt=0100 active, pulse rst for 1 cycle with req=1100 -> cycle after rst gnt=0000. Next cycle gnt=0100, because ptr was reset to 0 and the search from 0 finds 2 first.
